// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with hardwired-zero entry 0 and asynchronous clear.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.

module regfile_2r1w_bitcell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int ENTRIES = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [ENTRIES];
  logic              we  [ENTRIES];

  // Entry 0 has no storage at all, so address-0 writes have nothing to land in.
  assign mem[0] = '0;
  assign we[0]  = 1'b0;

  for (genvar i = 1; i < ENTRIES; i++) begin : g_entry
    assign we[i] = wr_en && (wr_addr == ADDR_W'(i));

    regfile_2r1w_bitcell #(.W(DATA_W)) u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (we[i]),
      .d     (wr_data),
      .q     (mem[i])
    );
  end

  logic [DATA_W-1:0] mux_a;
  logic [DATA_W-1:0] mux_b;

  always_comb begin
    mux_a = mem[rd_addr_a];
    mux_b = mem[rd_addr_b];
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  assign wr_live = wr_en && (wr_addr != '0);

  // Reset dominates so the bypass path can never leak wr_data while clearing.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!reset) begin
      rd_data_a = (wr_live && (rd_addr_a == wr_addr)) ? wr_data : mux_a;
      rd_data_b = (wr_live && (rd_addr_b == wr_addr)) ? wr_data : mux_b;
    end
  end
`else
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!reset) begin
      rd_data_a = mux_a;
      rd_data_b = mux_b;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed scenarios plus randomized traffic
// against an array-based reference model. Honors REGFILE_BYPASS_EN like the design.

module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_2r1w dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected combinational read result given the current write request.
  function automatic logic [31:0] expect_rd(input logic [4:0] ra);
    if (reset) return 32'h0;
    if (BYPASS && wr_en && wr_addr != 5'd0 && ra == wr_addr) return wr_data;
    return ref_mem[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
  endtask

  // Apply a write at the next rising edge; inputs change on the falling edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    if (a != 5'd0) ref_mem[a] = d;
    wr_en = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      check({tag, "_a"}, rd_data_a, ref_mem[i]);
      check({tag, "_b"}, rd_data_b, ref_mem[31 - i]);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd0;
    model_clear();
    #12;
    check("reset_rd_a", rd_data_a, 32'h0);
    check("reset_rd_b", rd_data_b, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Async clear mid-cycle, no clock edge inside the pulse.
    do_write(5'd5, 32'hDEADBEEF);
    rd_addr_a = 5'd5;
    #1;
    check("pre_reset_e5", rd_data_a, 32'hDEADBEEF);
    #1; reset = 1'b1;
    #1;
    check("async_reset_e5", rd_data_a, 32'h0);
    reset = 1'b0;
    model_clear();
    #1;
    check("post_reset_e5", rd_data_a, 32'h0);

    // Basic write/read with neighbours untouched.
    do_write(5'd7, 32'h12345678);
    rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    #1;
    check("wr7_a", rd_data_a, 32'h12345678);
    check("wr7_b", rd_data_b, 32'h12345678);
    rd_addr_a = 5'd6; rd_addr_b = 5'd8;
    #1;
    check("e6_zero", rd_data_a, 32'h0);
    check("e8_zero", rd_data_b, 32'h0);

    // Address-0 writes are discarded.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr_a = 5'd0;
    #1;
    check("zero_before", rd_data_a, 32'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("zero_after", rd_data_a, 32'h0);
    check_all("zero_nochg");

    // Same-cycle read of the entry being written.
    do_write(5'd9, 32'hAAAA0000);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000BBBB; rd_addr_a = 5'd9;
    #1;
    check("same_cycle", rd_data_a, BYPASS ? 32'h0000BBBB : 32'hAAAA0000);
    @(posedge clk);
    #1;
    ref_mem[9] = 32'h0000BBBB;
    wr_en = 1'b0;
    check("next_cycle", rd_data_a, 32'h0000BBBB);

    // Write enable gating.
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd3; wr_data = 32'h55555555; rd_addr_a = 5'd3;
    repeat (4) @(posedge clk);
    #1;
    check("en_off_e3", rd_data_a, 32'h0);
    do_write(5'd3, 32'h55555555);
    rd_addr_a = 5'd3;
    #1;
    check("en_on_e3", rd_data_a, 32'h55555555);

    // Write coincident with reset assertion is lost; next write lands normally.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFEF00D; rd_addr_a = 5'd4;
    @(posedge clk);
    reset = 1'b1;
    #1;
    wr_en = 1'b0;
    model_clear();
    check("coincide_rst_rd", rd_data_a, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("coincide_lost", rd_data_a, 32'h0);
    do_write(5'd4, 32'h0BADCAFE);
    #1;
    check("first_after_rst", rd_data_a, 32'h0BADCAFE);

    // Full sweep.
    for (int i = 1; i < 32; i++) do_write(5'(i), (32'(i) << 16) | 32'(i));
    check_all("sweep");

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      wr_en     = ($urandom_range(0, 3) != 0);
      wr_addr   = 5'($urandom);
      wr_data   = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      #1;
      check("rand_a", rd_data_a, expect_rd(rd_addr_a));
      check("rand_b", rd_data_b, expect_rd(rd_addr_b));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        #1;
        check("rand_rst_a", rd_data_a, 32'h0);
        check("rand_rst_b", rd_data_b, 32'h0);
        reset = 1'b0;
        model_clear();
      end
      @(posedge clk);
      #1;
      if (wr_en && wr_addr != 5'd0) ref_mem[wr_addr] = wr_data;
    end
    wr_en = 1'b0;
    check_all("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning the width of each register and data port in bits.
REQ-002 The block SHALL take parameter ADDR_W, default 5, meaning the address width; entry count is 2**ADDR_W (32 entries).
REQ-003 The block SHALL have port clk  input  1  single clock; all writes occur on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port wr_en  input  1  write enable, sampled on rising clk.
REQ-006 The block SHALL have port wr_addr  input  ADDR_W  write target entry index.
REQ-007 The block SHALL have port wr_data  input  DATA_W  write data.
REQ-008 The block SHALL have port rd_addr_a  input  ADDR_W  read port A entry index.
REQ-009 The block SHALL have port rd_addr_b  input  ADDR_W  read port B entry index.
REQ-010 The block SHALL have port rd_data_a  output  DATA_W  read port A data.
REQ-011 The block SHALL have port rd_data_b  output  DATA_W  read port B data.

Function
REQ-012 The storage SHALL hold 2**ADDR_W entries of DATA_W bits, each built from the team's enabled D flip-flop bit cells, with one decoded enable per entry.
REQ-013 Write decode SHALL assert the enable of exactly one entry, the entry at wr_addr, when wr_en=1 and wr_addr!=0, and SHALL assert no entry enable otherwise.
REQ-014 An enabled entry SHALL capture wr_data on the rising clk edge, giving one-cycle write latency; unenabled entries SHALL hold their value.
REQ-015 Entry 0 SHALL read as all-zero at all times; writes to address 0 SHALL be discarded with no side effect.
REQ-016 Reads SHALL be combinational, with zero-cycle latency: rd_data_x SHALL equal the stored contents of entry rd_addr_x, selected through a 2**ADDR_W:1 multiplexer per port.
REQ-017 Ports A and B SHALL be fully independent; the same address on both ports SHALL return identical data.
REQ-018 For a same-cycle read and write of one nonzero address, the read result SHALL be governed by REQ-023/REQ-024.
REQ-019 X or Z on rd_addr_x while wr_en=0 SHALL NOT corrupt stored contents.

Reset
REQ-020 Assertion of reset SHALL clear every entry to 0 immediately, independent of clk.
REQ-021 While reset=1, rd_data_a and rd_data_b SHALL both read 0 and writes SHALL be ignored.
REQ-022 A write whose clock edge coincides with reset assertion SHALL be lost; after reset deasserts, the first write SHALL take effect on the first rising edge with wr_en=1.

Configuration
REQ-023 With macro REGFILE_BYPASS_EN defined: when wr_en=1, wr_addr!=0, and rd_addr_x==wr_addr in the same cycle, rd_data_x SHALL equal wr_data combinationally (write-before-read), and reset SHALL still force 0 on both read ports.
REQ-024 With REGFILE_BYPASS_EN undefined: rd_data_x SHALL return the pre-edge stored value in that cycle and the new value from the following cycle (read-before-write); no bypass logic SHALL be present.

Verification
REQ-025 Reset scenario: write 0xDEADBEEF to entry 5, then assert reset for 1 ns mid-cycle -> rd_data_a (addr 5) reads 0 immediately, with no clk edge required.
REQ-026 Write/read scenario: write 0x12345678 to entry 7 -> rd_data_a=rd_data_b=0x12345678 from the cycle after the write edge; entry 6 and entry 8 remain 0.
REQ-027 Zero-register scenario: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_data_a (addr 0) reads 0 before and after the edge, and no other entry changes.
REQ-028 Same-cycle scenario: entry 9 holds 0xAAAA0000; write 0x0000BBBB to entry 9 while rd_addr_a=9 -> rd_data_a=0x0000BBBB during that cycle if REGFILE_BYPASS_EN is defined, otherwise 0xAAAA0000, and 0x0000BBBB in the next cycle in both builds.
REQ-029 Enable scenario: wr_en=0, wr_addr=3, wr_data=0x55555555 for 4 edges -> entry 3 unchanged at 0; then wr_en=1 for one edge -> entry 3=0x55555555.
REQ-030 Sweep scenario: write value (i<<16)|i to every entry i=1..31, then read all entries on both ports -> each returns its value, and entry 0 returns 0.
